// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bus from the NREQ requesters plus the registered
// regfile write port that the arbiter drives.
interface regfile_wb_arbiter_if #(
    parameter int NREQ   = 3,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_data;
    logic                   wr_en;
    logic [ADDR_W-1:0]      wr_addr;
    logic [DATA_W-1:0]      wr_data;

    modport master (
        output req_valid, req_addr, req_data,
        input  req_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  req_valid, req_addr, req_data,
        output req_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Per-requester writeback FIFOs drained round-robin into a single registered
// regfile write port, with r15 write rejection and a pending-address mask.
module regfile_wb_arbiter #(
    parameter int NREQ       = 3,
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 4,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_wb_arbiter_if.slave  bus,
    output logic [2**ADDR_W-1:0] pend_mask,
    output logic                 err_r15,
    output logic [15:0]          wr_count
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] ADDR_R15 = ADDR_W'(15);
    localparam logic [IDX_W-1:0]  LAST_RST = IDX_W'(NREQ - 1);

    logic [ADDR_W-1:0] fifo_addr [NREQ][FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [NREQ][FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr    [NREQ];
    logic [PTR_W-1:0]  wr_ptr    [NREQ];
    logic [CNT_W-1:0]  count     [NREQ];
    logic [IDX_W-1:0]  last;

    logic [NREQ-1:0]   push;
    logic [NREQ-1:0]   enq;
    logic [NREQ-1:0]   pop;
    logic [NREQ-1:0]   nonempty;
    logic              r15_hit;
    logic              grant_any;
    logic [IDX_W-1:0]  grant_idx;
    logic [IDX_W-1:0]  cand;

    // Readiness looks only at the pre-pop count, so a full FIFO never passes through.
    always_comb begin
        push          = '0;
        enq           = '0;
        nonempty      = '0;
        r15_hit       = 1'b0;
        bus.req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_ready[i] = !reset && (count[i] < DEPTH_C);
            push[i]          = bus.req_valid[i] && bus.req_ready[i];
            enq[i]           = push[i] && (bus.req_addr[i*ADDR_W +: ADDR_W] != ADDR_R15);
            nonempty[i]      = (count[i] != '0);
            if (push[i] && !enq[i]) begin
                r15_hit = 1'b1;
            end
        end
    end

    always_comb begin
        grant_any = 1'b0;
        grant_idx = last;
        cand      = last;
        pop       = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDX_W'((int'(last) + k) % NREQ);
            if (!grant_any && nonempty[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
        if (grant_any) begin
            pop[grant_idx] = 1'b1;
        end
    end

    // Valid entries occupy the count slots starting at the read pointer.
    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < NREQ; i++) begin
            for (int o = 0; o < FIFO_DEPTH; o++) begin
                if (CNT_W'(o) < count[i]) begin
                    pend_mask[fifo_addr[i][rd_ptr[i] + PTR_W'(o)]] = 1'b1;
                end
            end
        end
        if (bus.wr_en) begin
            pend_mask[bus.wr_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (enq[i]) begin
                fifo_addr[i][wr_ptr[i]] <= bus.req_addr[i*ADDR_W +: ADDR_W];
                fifo_data[i][wr_ptr[i]] <= bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREQ; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                count[i]  <= '0;
            end
            last        <= LAST_RST;
            bus.wr_en   <= 1'b0;
            bus.wr_addr <= '0;
            bus.wr_data <= '0;
            err_r15     <= 1'b0;
            wr_count    <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (enq[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                end
                if (enq[i] && !pop[i]) begin
                    count[i] <= count[i] + CNT_W'(1);
                end else if (!enq[i] && pop[i]) begin
                    count[i] <= count[i] - CNT_W'(1);
                end
            end
            if (r15_hit) begin
                err_r15 <= 1'b1;
            end
            // wr_addr/wr_data hold their last values on idle cycles.
            bus.wr_en <= grant_any;
            if (grant_any) begin
                bus.wr_addr <= fifo_addr[grant_idx][rd_ptr[grant_idx]];
                bus.wr_data <= fifo_data[grant_idx][rd_ptr[grant_idx]];
                last        <= grant_idx;
                wr_count    <= wr_count + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: queue-based reference model checked
// every cycle, plus literal expectations for each directed scenario.
module tb_regfile_wb_arbiter;
    localparam int NREQ   = 3;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 2;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } ent_t;

    typedef struct {
        int                cyc;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wlog_t;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [2**ADDR_W-1:0]   pend_mask;
    logic                   err_r15;
    logic [15:0]            wr_count;
    logic [NREQ-1:0]        drv_valid;
    logic [NREQ*ADDR_W-1:0] drv_addr;
    logic [NREQ*DATA_W-1:0] drv_data;

    regfile_wb_arbiter_if #(.NREQ(NREQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    regfile_wb_arbiter #(
        .NREQ(NREQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .pend_mask(pend_mask),
        .err_r15(err_r15),
        .wr_count(wr_count)
    );

    assign bus.req_valid = drv_valid;
    assign bus.req_addr  = drv_addr;
    assign bus.req_data  = drv_data;

    always #5 clk = ~clk;

    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;
    ent_t  stim [NREQ][$];
    ent_t  mq   [NREQ][$];
    wlog_t wlog [$];
    int    xfer_cyc  [NREQ];
    int    stall_cnt [NREQ];

    int                m_last;
    logic              m_wr_en;
    logic [ADDR_W-1:0] m_wr_addr;
    logic [DATA_W-1:0] m_wr_data;
    logic              m_err;
    logic [15:0]       m_count;
    logic [NREQ-1:0]   m_take;
    ent_t              m_e;
    int                m_g;
    bit                m_found;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input int req, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
        ent_t e;
        e.addr = addr;
        e.data = data;
        stim[req].push_back(e);
    endtask

    function automatic bit busy();
        bit b;
        b = (|drv_valid) || bus.wr_en || (pend_mask != '0);
        for (int i = 0; i < NREQ; i++) begin
            if (stim[i].size() > 0) b = 1'b1;
        end
        return b;
    endfunction

    task automatic waitIdle(input string name, input int budget);
        int n;
        n = 0;
        while (busy() && n < budget) begin
            @(negedge clk);
            #2;
            n++;
        end
        checkOutput({name, " timeout"}, 32'(n >= budget), 32'd0);
    endtask

    // Driver: presents each requester's stimulus queue head and holds it until accepted.
    initial begin
        drv_valid = '0;
        drv_addr  = '0;
        drv_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            xfer_cyc[i]  = 0;
            stall_cnt[i] = 0;
        end
        forever begin
            @(negedge clk);
            if (reset) begin
                drv_valid = '0;
                for (int i = 0; i < NREQ; i++) stim[i].delete();
            end else begin
                for (int i = 0; i < NREQ; i++) begin
                    if (stim[i].size() > 0) begin
                        drv_valid[i]                  = 1'b1;
                        drv_addr[i*ADDR_W +: ADDR_W]  = stim[i][0].addr;
                        drv_data[i*DATA_W +: DATA_W]  = stim[i][0].data;
                    end else begin
                        drv_valid[i] = 1'b0;
                    end
                end
                #1;
                for (int i = 0; i < NREQ; i++) begin
                    if (drv_valid[i]) begin
                        if (bus.req_ready[i]) begin
                            void'(stim[i].pop_front());
                            xfer_cyc[i] = cyc + 1;
                        end else begin
                            stall_cnt[i]++;
                        end
                    end
                end
            end
        end
    end

    // Reference model: one queue per requester, round-robin pick from the pre-push queues.
    initial begin
        m_last = NREQ - 1; m_wr_en = 1'b0; m_wr_addr = '0; m_wr_data = '0;
        m_err = 1'b0; m_count = '0;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                for (int i = 0; i < NREQ; i++) mq[i].delete();
                m_last = NREQ - 1; m_wr_en = 1'b0; m_wr_addr = '0; m_wr_data = '0;
                m_err = 1'b0; m_count = '0;
            end else begin
                for (int i = 0; i < NREQ; i++) begin
                    m_take[i] = bus.req_valid[i] && (mq[i].size() < DEPTH);
                end
                m_found = 1'b0;
                m_g     = 0;
                for (int k = 1; k <= NREQ; k++) begin
                    if (!m_found && mq[(m_last + k) % NREQ].size() > 0) begin
                        m_found = 1'b1;
                        m_g     = (m_last + k) % NREQ;
                    end
                end
                if (m_found) begin
                    m_e       = mq[m_g].pop_front();
                    m_wr_en   = 1'b1;
                    m_wr_addr = m_e.addr;
                    m_wr_data = m_e.data;
                    m_last    = m_g;
                    m_count   = m_count + 16'd1;
                end else begin
                    m_wr_en = 1'b0;
                end
                for (int i = 0; i < NREQ; i++) begin
                    if (m_take[i]) begin
                        m_e.addr = bus.req_addr[i*ADDR_W +: ADDR_W];
                        m_e.data = bus.req_data[i*DATA_W +: DATA_W];
                        if (m_e.addr == 4'd15) m_err = 1'b1;
                        else mq[i].push_back(m_e);
                    end
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    initial begin
        logic [NREQ-1:0]      exp_ready;
        logic [2**ADDR_W-1:0] exp_pend;
        forever begin
            @(negedge clk);
            exp_pend = '0;
            for (int i = 0; i < NREQ; i++) begin
                exp_ready[i] = !reset && (mq[i].size() < DEPTH);
                for (int j = 0; j < mq[i].size(); j++) exp_pend[mq[i][j].addr] = 1'b1;
            end
            if (m_wr_en) exp_pend[m_wr_addr] = 1'b1;
            checkOutput("cyc wr_en",     32'(bus.wr_en),     32'(m_wr_en));
            checkOutput("cyc wr_addr",   32'(bus.wr_addr),   32'(m_wr_addr));
            checkOutput("cyc wr_data",   32'(bus.wr_data),   32'(m_wr_data));
            checkOutput("cyc req_ready", 32'(bus.req_ready), 32'(exp_ready));
            checkOutput("cyc pend_mask", 32'(pend_mask),     32'(exp_pend));
            checkOutput("cyc err_r15",   32'(err_r15),       32'(m_err));
            checkOutput("cyc wr_count",  32'(wr_count),      32'(m_count));
        end
    end

    initial begin
        wlog_t wl;
        forever begin
            @(negedge clk);
            if (bus.wr_en) begin
                wl.cyc  = cyc;
                wl.addr = bus.wr_addr;
                wl.data = bus.wr_data;
                wlog.push_back(wl);
            end
        end
    end

    initial begin
        int base;
        int s0;
        int n0;
        int n5;
        int n6;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        checkOutput("reset wr_en",     32'(bus.wr_en),     32'd0);
        checkOutput("reset wr_addr",   32'(bus.wr_addr),   32'd0);
        checkOutput("reset wr_data",   32'(bus.wr_data),   32'd0);
        checkOutput("reset req_ready", 32'(bus.req_ready), 32'd0);
        checkOutput("reset pend_mask", 32'(pend_mask),     32'd0);
        checkOutput("reset err_r15",   32'(err_r15),       32'd0);
        checkOutput("reset wr_count",  32'(wr_count),      32'd0);
        reset = 1'b0;

        $display("[TB] single write");
        base = wlog.size();
        applyStimulus(1, 4'd3, 16'hABCD);
        waitIdle("single", 50);
        checkOutput("single count",   32'(wlog.size() - base), 32'd1);
        checkOutput("single addr",    32'(wlog[base].addr),    32'd3);
        checkOutput("single data",    32'(wlog[base].data),    32'hABCD);
        checkOutput("single latency", 32'(wlog[base].cyc - xfer_cyc[1]), 32'd1);
        checkOutput("single wr_count", 32'(wr_count), 32'd1);

        // Requester 1 was granted last, so the rotation starts at requester 2.
        $display("[TB] round robin");
        base = wlog.size();
        for (int n = 1; n <= 4; n++) begin
            for (int i = 0; i < NREQ; i++) applyStimulus(i, 4'(i), 16'(i * 256 + n));
        end
        waitIdle("rr", 100);
        checkOutput("rr count", 32'(wlog.size() - base), 32'd12);
        for (int j = 0; j < 12; j++) begin
            checkOutput("rr addr", 32'(wlog[base + j].addr), 32'((2 + j) % 3));
            checkOutput("rr data", 32'(wlog[base + j].data), 32'(((2 + j) % 3) * 256 + j / 3 + 1));
            checkOutput("rr back-to-back", 32'(wlog[base + j].cyc - wlog[base].cyc), 32'(j));
        end

        $display("[TB] backpressure");
        base = wlog.size();
        s0   = stall_cnt[0];
        for (int n = 1; n <= 8; n++) begin
            applyStimulus(1, 4'd5, 16'(16'h1100 + n));
            applyStimulus(2, 4'd6, 16'(16'h2200 + n));
        end
        repeat (4) @(negedge clk);
        #2;
        for (int n = 1; n <= 5; n++) applyStimulus(0, 4'd2, 16'(16'h0A00 + n));
        waitIdle("bp", 200);
        n0 = 0; n5 = 0; n6 = 0;
        for (int j = base; j < wlog.size(); j++) begin
            if (wlog[j].addr == 4'd2) begin
                n0++;
                checkOutput("bp r0 order", 32'(wlog[j].data), 32'(16'h0A00 + n0));
            end
            if (wlog[j].addr == 4'd5) n5++;
            if (wlog[j].addr == 4'd6) n6++;
        end
        checkOutput("bp r0 writes",  32'(n0), 32'd5);
        checkOutput("bp r1 writes",  32'(n5), 32'd8);
        checkOutput("bp r2 writes",  32'(n6), 32'd8);
        checkOutput("bp r0 stalled", 32'(stall_cnt[0] - s0 > 0), 32'd1);
        checkOutput("bp wr_count",   32'(wr_count), 32'd34);

        $display("[TB] r15 reject");
        base = wlog.size();
        s0   = stall_cnt[2];
        applyStimulus(2, 4'd15, 16'h1234);
        waitIdle("r15", 50);
        checkOutput("r15 no stall", 32'(stall_cnt[2] - s0), 32'd0);
        checkOutput("r15 no write", 32'(wlog.size() - base), 32'd0);
        checkOutput("r15 err",      32'(err_r15), 32'd1);
        repeat (100) @(negedge clk);
        #2;
        checkOutput("r15 err sticky", 32'(err_r15), 32'd1);
        checkOutput("r15 wr_count",   32'(wr_count), 32'd34);

        $display("[TB] reset mid-stream");
        for (int n = 0; n < 3; n++) begin
            applyStimulus(0, 4'd9,  16'(16'h9000 + n));
            applyStimulus(1, 4'd10, 16'(16'hA000 + n));
            applyStimulus(2, 4'd11, 16'(16'hB000 + n));
        end
        repeat (3) @(negedge clk);
        #2;
        checkOutput("pre-reset wr_en", 32'(bus.wr_en), 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("async wr_en",     32'(bus.wr_en),     32'd0);
        checkOutput("async pend_mask", 32'(pend_mask),     32'd0);
        checkOutput("async req_ready", 32'(bus.req_ready), 32'd0);
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b0;
        base = wlog.size();
        applyStimulus(0, 4'd7, 16'h7777);
        applyStimulus(1, 4'd8, 16'h8888);
        waitIdle("post-reset", 50);
        checkOutput("post-reset count",  32'(wlog.size() - base), 32'd2);
        checkOutput("post-reset first",  32'(wlog[base].addr),     32'd7);
        checkOutput("post-reset second", 32'(wlog[base + 1].addr), 32'd8);
        checkOutput("post-reset wr_count", 32'(wr_count), 32'd2);
        checkOutput("post-reset err",      32'(err_r15),  32'd0);

        $display("[TB] counter wrap");
        reset = 1'b1;
        @(negedge clk);
        #2;
        reset = 1'b0;
        base = wlog.size();
        for (int n = 0; n < 65537; n++) applyStimulus(0, 4'(n % 15), 16'(n));
        waitIdle("wrap", 70000);
        checkOutput("wrap writes",   32'(wlog.size() - base), 32'd65537);
        checkOutput("wrap wr_count", 32'(wr_count), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
